bus_dma_engine: RTL and testbench
=================================

Name: bus_dma_engine

Overview:
- 8-bit memory-to-memory DMA master on the shared microprocessor bus, directly upstream of the data RAM.
- Moves a block of bytes RAM-to-RAM without CPU load/store loops.
- CPU programs it through a 4-byte register window on the same bus, then grants the bus via a request/grant pair.
- Raises a bus interrupt on completion.

Parameters:
DMABaseAddr, 8'hC0, base of 4-register window (SRC, DST, LEN, CTRL at +0..+3)
IdleAddr, 8'hFF, unmapped address driven during turnaround cycles; must decode to no slave

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous active-high reset
BUS_DATA  inout  8  shared tristate data bus
BUS_ADDR  in  8  arbitrated bus address as seen by slaves (register decode)
BUS_WE  in  1  arbitrated bus write enable (register decode)
DMA_BUS_ADDR  out  8  address driven when master; top level muxes on BUS_GNT
DMA_BUS_WE  out  1  write enable driven when master
BUS_REQ  out  1  bus request to CPU/arbiter
BUS_GNT  in  1  bus grant; once high, held until BUS_REQ falls
BUS_INTERRUPT_RAISE  out  1  transfer-complete interrupt
BUS_INTERRUPT_ACK  in  1  interrupt acknowledge

Behaviour:
- Clock and reset: CLK is the only clock. RESET is synchronous and active-high.
- Reset values: SRC=DST=LEN=0, CTRL.IE=0, done=0, state IDLE, BUS_REQ=0, DMA_BUS_ADDR=IdleAddr, DMA_BUS_WE=0, BUS_INTERRUPT_RAISE=0, BUS_DATA released (Z).
- Register slave (active only while BUS_GNT=0):
  - BUS_ADDR in [DMABaseAddr, DMABaseAddr+3] with BUS_WE=1 writes the register on the clock edge.
  - With BUS_WE=0, the register value drives BUS_DATA in the following cycle (1-cycle registered read, same timing as RAM). Otherwise BUS_DATA is Z.
- CTRL write: bit0=start (self-clearing), bit1=IE (stored).
- CTRL read: {5'b0, IE, done, busy}.
- Writes to SRC/DST/LEN/CTRL while busy are ignored.
- Start with LEN=0: done=1 next cycle, no BUS_REQ, IRQ raised if IE=1.
- Start with LEN!=0: clears done, sets busy.
- FSM states:
  - IDLE: on start with LEN!=0, go to REQ.
  - REQ: BUS_REQ=1. Wait for BUS_GNT=1, then go to RD_ADDR.
  - RD_ADDR: DMA_BUS_ADDR=SRC, WE=0. If BUS_GNT=0, return to REQ. Else go to RD_DATA.
  - RD_DATA: DMA_BUS_ADDR=IdleAddr, WE=0. This cycle is the turnaround that forces the RAM to release BUS_DATA next cycle. Latch BUS_DATA (RAM output for SRC) at end of cycle. Go to WR.
  - WR: DMA_BUS_ADDR=DST, WE=1, BUS_DATA driven with latched byte. At edge: SRC+=1, DST+=1, LEN-=1. If old LEN==1, go to DONE, else go to RD_ADDR.
  - DONE: BUS_REQ=0, DMA_BUS_ADDR=IdleAddr, busy=0, done=1. Set BUS_INTERRUPT_RAISE if IE. Go to IDLE.
- Throughput: 3 cycles per byte. N bytes take 3N cycles from first RD_ADDR; BUS_REQ falls in the DONE cycle.
- BUS_REQ stays high from REQ through the last WR. The bus is held for the whole block.
- Address arithmetic is 8-bit modulo 256. SRC/DST wrap 0xFF to 0x00. Final SRC/DST/LEN are readable after completion (LEN reads 0).
- Overlapping regions are copied strictly ascending. No overlap correction.
- While granted, the register window is not decoded. A SRC/DST inside the window gives undefined data and must not be used.
- Interrupt:
  - BUS_INTERRUPT_RAISE clears on BUS_INTERRUPT_ACK.
  - If DONE raise and ACK occur in the same cycle, raise wins.
- RESET mid-transfer: all state returns to reset values next edge. BUS_REQ drops and a partial copy remains in RAM.

Test Plan:
- Reset: assert RESET 2 cycles mid-transfer -> BUS_REQ=0, DMA_BUS_WE=0, DMA_BUS_ADDR=0xFF, CTRL reads 0x00, BUS_DATA Z.
- Registers: CPU writes C0=0x10, C1=0x40, C2=0x04, then reads back -> 0x10, 0x40, 0x04 on BUS_DATA one cycle after each read address.
- Copy: RAM[0x10..0x13]=A1,B2,C3,D4; CTRL=0x03; grant after 2 cycles -> RAM[0x40..0x43]=A1,B2,C3,D4.
  - Exactly 12 bus cycles from first RD_ADDR.
  - Address sequence 10,FF,40,11,FF,41,...
  - IRQ raised; CTRL reads 0x06.
- LEN=0 start: CTRL=0x03 -> BUS_REQ never rises, done=1 next cycle, IRQ=1; ACK -> IRQ=0.
- Busy lockout and wrap: SRC=0xFE, LEN=3, start, then write SRC=0x00 while busy -> ignored; read addresses FE, FF, 00; final SRC reads 0x01.
- IRQ/ACK collision: ACK asserted in the DONE cycle -> BUS_INTERRUPT_RAISE=1 afterwards; cleared by a later ACK.

Source files
------------

// File: rtl/bus_dma_engine.sv
// Byte-wide RAM-to-RAM DMA master with a 4-register CPU window.
// Copies LEN bytes ascending from SRC to DST at 3 bus cycles per byte.
module bus_dma_engine #(
    parameter logic [7:0] DMABaseAddr = 8'hC0,
    parameter logic [7:0] IdleAddr    = 8'hFF
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic [7:0] DMA_BUS_ADDR,
    output logic       DMA_BUS_WE,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [7:0] src_q;
    logic [7:0] dst_q;
    logic [7:0] len_q;
    logic       ie_q;
    logic       done_q;
    logic       req_q;
    logic [7:0] addr_q;
    logic       we_q;
    logic       irq_q;
    logic [7:0] byte_q;
    logic       wr_drv_q;
    logic       rd_drv_q;
    logic [7:0] rd_val_q;

    logic [7:0] off_d;
    logic       sel_d;
    logic       busy_d;
    logic       wr_en_d;
    logic       start_d;
    logic [7:0] reg_rd_d;

    assign off_d   = BUS_ADDR - DMABaseAddr;
    assign sel_d   = !BUS_GNT && (off_d < 8'd4);
    assign busy_d  = (state_q != S_IDLE) && (state_q != S_DONE);
    // Register writes are locked out for the whole transfer, DONE included
    assign wr_en_d = sel_d && BUS_WE && (state_q == S_IDLE);
    assign start_d = wr_en_d && (off_d[1:0] == 2'd3) && BUS_DATA[0];

    always_comb begin
        reg_rd_d = 8'h00;
        unique case (off_d[1:0])
            2'd0: reg_rd_d = src_q;
            2'd1: reg_rd_d = dst_q;
            2'd2: reg_rd_d = len_q;
            2'd3: reg_rd_d = {5'b0, ie_q, done_q, busy_d};
        endcase
    end

    assign BUS_DATA = wr_drv_q ? byte_q :
                      rd_drv_q ? rd_val_q : 8'hzz;

    assign DMA_BUS_ADDR        = addr_q;
    assign DMA_BUS_WE          = we_q;
    assign BUS_REQ             = req_q;
    assign BUS_INTERRUPT_RAISE = irq_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            src_q    <= 8'h00;
            dst_q    <= 8'h00;
            len_q    <= 8'h00;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= IdleAddr;
            we_q     <= 1'b0;
            irq_q    <= 1'b0;
            byte_q   <= 8'h00;
            wr_drv_q <= 1'b0;
            rd_drv_q <= 1'b0;
            rd_val_q <= 8'h00;
        end else begin
            rd_drv_q <= sel_d && !BUS_WE;
            rd_val_q <= reg_rd_d;

            // A raise later in this block overrides a same-cycle ack
            if (BUS_INTERRUPT_ACK) begin
                irq_q <= 1'b0;
            end

            if (wr_en_d) begin
                unique case (off_d[1:0])
                    2'd0: src_q <= BUS_DATA;
                    2'd1: dst_q <= BUS_DATA;
                    2'd2: len_q <= BUS_DATA;
                    2'd3: ie_q  <= BUS_DATA[1];
                endcase
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        if (len_q == 8'h00) begin
                            done_q <= 1'b1;
                            if (BUS_DATA[1]) begin
                                irq_q <= 1'b1;
                            end
                        end else begin
                            done_q  <= 1'b0;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (BUS_GNT) begin
                        addr_q  <= src_q;
                        state_q <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    addr_q  <= IdleAddr;
                    state_q <= BUS_GNT ? S_RD_DATA : S_REQ;
                end
                S_RD_DATA: begin
                    // RAM drives the SRC byte during this turnaround cycle
                    byte_q   <= BUS_DATA;
                    addr_q   <= dst_q;
                    we_q     <= 1'b1;
                    wr_drv_q <= 1'b1;
                    state_q  <= S_WR;
                end
                S_WR: begin
                    src_q    <= src_q + 8'd1;
                    dst_q    <= dst_q + 8'd1;
                    len_q    <= len_q - 8'd1;
                    we_q     <= 1'b0;
                    wr_drv_q <= 1'b0;
                    if (len_q == 8'd1) begin
                        addr_q  <= IdleAddr;
                        req_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= src_q + 8'd1;
                        state_q <= S_RD_ADDR;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    if (ie_q) begin
                        irq_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma_engine.sv
// Bench for bus_dma_engine: CPU bus model, byte RAM below 0xC0, arbiter grant.
// Register accesses come from a vector table; transfers are scored per cycle.
module tb_bus_dma_engine;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] cpu_addr = 8'hFF;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_we = 1'b0;
    logic       cpu_drv = 1'b0;
    logic       gnt = 1'b0;
    logic       ack = 1'b0;

    wire  [7:0] BUS_DATA;
    logic [7:0] DMA_BUS_ADDR;
    logic       DMA_BUS_WE;
    logic       BUS_REQ;
    logic       irq;
    logic [7:0] bus_addr;
    logic       bus_we;

    logic [7:0] mem [256];
    logic       ram_drv = 1'b0;
    logic [7:0] ram_q = 8'h00;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_a[$];

    always #5 CLK = ~CLK;

    assign bus_addr = gnt ? DMA_BUS_ADDR : cpu_addr;
    assign bus_we   = gnt ? DMA_BUS_WE : cpu_we;
    assign BUS_DATA = cpu_drv ? cpu_data : 8'hzz;
    assign BUS_DATA = ram_drv ? ram_q : 8'hzz;

    // RAM with one-cycle registered read, mapped below the DMA window
    always @(posedge CLK) begin
        ram_drv <= 1'b0;
        if (bus_addr < 8'hC0) begin
            if (bus_we) begin
                mem[bus_addr] <= BUS_DATA;
            end else begin
                ram_drv <= 1'b1;
                ram_q   <= mem[bus_addr];
            end
        end
    end

    bus_dma_engine dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .BUS_DATA            (BUS_DATA),
        .BUS_ADDR            (bus_addr),
        .BUS_WE              (bus_we),
        .DMA_BUS_ADDR        (DMA_BUS_ADDR),
        .DMA_BUS_WE          (DMA_BUS_WE),
        .BUS_REQ             (BUS_REQ),
        .BUS_GNT             (gnt),
        .BUS_INTERRUPT_RAISE (irq),
        .BUS_INTERRUPT_ACK   (ack)
    );

    typedef struct {
        logic [7:0] a;
        logic       we;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", nm, act, ex);
        end
    endtask

    task automatic chk_released(input string nm);
        total++;
        if (!(BUS_DATA === 8'hzz || BUS_DATA === 8'h00)) begin
            bad++;
            $display("FAIL %s: got %02h want released", nm, BUS_DATA);
        end
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_we   = 1'b1;
        cpu_drv  = 1'b1;
        @(posedge CLK);
        #1;
        cpu_we   = 1'b0;
        cpu_drv  = 1'b0;
        cpu_addr = 8'hFF;
    endtask

    task automatic cpu_rd(input logic [7:0] a, input logic [7:0] ex,
                          input string nm);
        cpu_addr = a;
        exp_q.push_back(ex);
        @(posedge CLK);
        #1;
        cpu_addr = 8'hFF;
        @(negedge CLK);
        chk(nm, BUS_DATA, exp_q.pop_front());
        @(posedge CLK);
        #1;
    endtask

    task automatic push_seq(input logic [7:0] s, input logic [7:0] d,
                            input int n);
        logic [7:0] ss;
        logic [7:0] dd;
        ss = s;
        dd = d;
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(ss);
            exp_a.push_back(8'hFF);
            exp_a.push_back(dd);
            ss = ss + 8'd1;
            dd = dd + 8'd1;
        end
    endtask

    // Grants the bus, scores 3n cycles of address/we, then the DONE cycle
    task automatic xfer(input int n, input logic ack_done, input string nm);
        @(negedge CLK);
        chk({nm, "_req_up"}, {7'b0, BUS_REQ}, 8'h01);
        @(posedge CLK);
        #1;
        gnt = 1'b1;
        @(posedge CLK);
        for (int k = 0; k < 3 * n; k++) begin
            @(negedge CLK);
            chk({nm, "_addr"}, DMA_BUS_ADDR, exp_a.pop_front());
            chk({nm, "_we"}, {7'b0, DMA_BUS_WE}, {7'b0, (k % 3) == 2});
            chk({nm, "_req_hold"}, {7'b0, BUS_REQ}, 8'h01);
            @(posedge CLK);
        end
        @(negedge CLK);
        chk({nm, "_req_fall"}, {7'b0, BUS_REQ}, 8'h00);
        chk({nm, "_done_addr"}, DMA_BUS_ADDR, 8'hFF);
        ack = ack_done;
        @(posedge CLK);
        #1;
        gnt = 1'b0;
        ack = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'hC0, 1'b1, 8'h10};
        tbl[1] = '{8'hC1, 1'b1, 8'h40};
        tbl[2] = '{8'hC2, 1'b1, 8'h04};
        tbl[3] = '{8'hC0, 1'b0, 8'h10};
        tbl[4] = '{8'hC1, 1'b0, 8'h40};
        tbl[5] = '{8'hC2, 1'b0, 8'h04};
        tbl[6] = '{8'hC3, 1'b0, 8'h00};

        @(posedge CLK);
        @(negedge CLK);
        chk("rst_req", {7'b0, BUS_REQ}, 8'h00);
        chk("rst_addr", DMA_BUS_ADDR, 8'hFF);
        chk("rst_we", {7'b0, DMA_BUS_WE}, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk_released("rst_bus");
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cpu_rd(8'hC3, 8'h00, "rst_ctrl");

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].we) begin
                cpu_wr(tbl[i].a, tbl[i].d);
            end else begin
                cpu_rd(tbl[i].a, tbl[i].d, $sformatf("reg_%0d", i));
            end
        end

        cpu_wr(8'h10, 8'hA1);
        cpu_wr(8'h11, 8'hB2);
        cpu_wr(8'h12, 8'hC3);
        cpu_wr(8'h13, 8'hD4);
        cpu_wr(8'hC3, 8'h03);
        push_seq(8'h10, 8'h40, 4);
        xfer(4, 1'b0, "copy");
        @(negedge CLK);
        chk("copy_irq", {7'b0, irq}, 8'h01);
        cpu_rd(8'hC3, 8'h06, "copy_ctrl");
        cpu_rd(8'h40, 8'hA1, "copy_m0");
        cpu_rd(8'h41, 8'hB2, "copy_m1");
        cpu_rd(8'h42, 8'hC3, "copy_m2");
        cpu_rd(8'h43, 8'hD4, "copy_m3");
        cpu_rd(8'hC0, 8'h14, "copy_src");
        cpu_rd(8'hC1, 8'h44, "copy_dst");
        cpu_rd(8'hC2, 8'h00, "copy_len");

        ack = 1'b1;
        @(posedge CLK);
        #1;
        ack = 1'b0;
        @(negedge CLK);
        chk("ack_clr", {7'b0, irq}, 8'h00);
        cpu_wr(8'hC3, 8'h03);
        @(negedge CLK);
        chk("len0_irq", {7'b0, irq}, 8'h01);
        chk("len0_req", {7'b0, BUS_REQ}, 8'h00);
        cpu_rd(8'hC3, 8'h06, "len0_ctrl");
        chk("len0_req2", {7'b0, BUS_REQ}, 8'h00);
        ack = 1'b1;
        @(posedge CLK);
        #1;
        ack = 1'b0;
        @(negedge CLK);
        chk("len0_ack", {7'b0, irq}, 8'h00);
        chk("len0_req3", {7'b0, BUS_REQ}, 8'h00);

        cpu_wr(8'hC0, 8'hFE);
        cpu_wr(8'hC1, 8'h20);
        cpu_wr(8'hC2, 8'h03);
        cpu_wr(8'hC3, 8'h01);
        cpu_wr(8'hC0, 8'h00);
        push_seq(8'hFE, 8'h20, 3);
        xfer(3, 1'b0, "wrap");
        @(negedge CLK);
        chk("wrap_irq", {7'b0, irq}, 8'h00);
        cpu_rd(8'hC0, 8'h01, "wrap_src");
        cpu_rd(8'hC1, 8'h23, "wrap_dst");
        cpu_rd(8'hC2, 8'h00, "wrap_len");
        cpu_rd(8'hC3, 8'h02, "wrap_ctrl");

        cpu_wr(8'hC0, 8'h10);
        cpu_wr(8'hC1, 8'h50);
        cpu_wr(8'hC2, 8'h01);
        cpu_wr(8'hC3, 8'h03);
        push_seq(8'h10, 8'h50, 1);
        xfer(1, 1'b1, "coll");
        @(negedge CLK);
        chk("coll_irq", {7'b0, irq}, 8'h01);
        ack = 1'b1;
        @(posedge CLK);
        #1;
        ack = 1'b0;
        @(negedge CLK);
        chk("coll_ack", {7'b0, irq}, 8'h00);
        cpu_rd(8'h50, 8'hA1, "coll_m0");

        cpu_wr(8'hC0, 8'h10);
        cpu_wr(8'hC1, 8'h60);
        cpu_wr(8'hC2, 8'h04);
        cpu_wr(8'hC3, 8'h03);
        gnt = 1'b1;
        repeat (6) begin
            @(posedge CLK);
        end
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("mid_req", {7'b0, BUS_REQ}, 8'h00);
        chk("mid_we", {7'b0, DMA_BUS_WE}, 8'h00);
        chk("mid_addr", DMA_BUS_ADDR, 8'hFF);
        gnt = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk_released("mid_bus");
        chk("mid_irq", {7'b0, irq}, 8'h00);
        cpu_rd(8'hC3, 8'h00, "mid_ctrl");
        cpu_rd(8'hC0, 8'h00, "mid_src");
        cpu_rd(8'h60, 8'hA1, "mid_part");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
